// File: rtl/fetch_pc_stage_if.sv
// Instruction-memory request/ready bus between the fetch stage (master) and imem (slave).
interface fetch_pc_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic [31:0]     imem_rdata;

    modport master (output imem_req, imem_addr, input  imem_ready, imem_rdata);
    modport slave  (input  imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/fetch_pc_stage.sv
// IF stage: owns the PC, fetches over the imem bus, loads IF/ID; one-entry skid
// absorbs stalls, wrong-path requests are drained in DROP after a redirect.
module fetch_pc_stage #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc,
    fetch_pc_stage_if.master    imem,
    output logic                if_id_valid,
    output logic [XLEN-1:0]     if_id_pc,
    output logic [31:0]         if_id_instr
);
    typedef enum logic [1:0] {BOOT, FETCH, HOLD, DROP} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_q, pend_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;
    logic [31:0]     skid_instr_q, skid_instr_d;
    logic            req_q, req_d;
    logic            valid_d;
    logic [XLEN-1:0] ipc_d;
    logic [31:0]     instr_d;
    logic [XLEN-1:0] redir_tgt;
    logic [XLEN-1:0] pc_inc;

    // imem_addr is the PC register itself; in DROP the PC still holds the stale address.
    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;

    assign redir_tgt = redirect_pc & ~XLEN'(3);
    assign pc_inc    = pc_q + XLEN'(4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            pend_q       <= '0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
            req_q        <= 1'b0;
            if_id_valid  <= 1'b0;
            if_id_pc     <= '0;
            if_id_instr  <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_q       <= pend_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            req_q        <= req_d;
            if_id_valid  <= valid_d;
            if_id_pc     <= ipc_d;
            if_id_instr  <= instr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_d       = pend_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        valid_d      = if_id_valid;
        ipc_d        = if_id_pc;
        instr_d      = if_id_instr;

        unique case (state_q)
            BOOT: begin
                state_d = FETCH;
                if (redirect_valid) begin
                    pc_d    = redir_tgt;
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                end
            end
            FETCH: begin
                if (redirect_valid) begin
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                    if (imem.imem_ready) begin
                        pc_d = redir_tgt;
                    end else begin
                        pend_d  = redir_tgt;
                        state_d = DROP;
                    end
                end else if (imem.imem_ready) begin
                    pc_d = pc_inc;
                    if (stall) begin
                        skid_pc_d    = pc_q;
                        skid_instr_d = imem.imem_rdata;
                        state_d      = HOLD;
                    end else begin
                        valid_d = 1'b1;
                        ipc_d   = pc_q;
                        instr_d = imem.imem_rdata;
                    end
                end else if (!stall) begin
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redir_tgt;
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                    state_d = FETCH;
                end else if (!stall) begin
                    valid_d = 1'b1;
                    ipc_d   = skid_pc_q;
                    instr_d = skid_instr_q;
                    state_d = FETCH;
                end
            end
            DROP: begin
                valid_d = 1'b0;
                instr_d = NOP_INSTR;
                if (imem.imem_ready) begin
                    pc_d    = redirect_valid ? redir_tgt : pend_q;
                    state_d = FETCH;
                end else if (redirect_valid) begin
                    pend_d = redir_tgt;
                end
            end
            default: state_d = BOOT;
        endcase

        req_d = (state_d == FETCH) || (state_d == DROP);
    end
endmodule

// File: doc/fetch_pc_stage.md
Name: fetch_pc_stage

Overview:
- Instruction-fetch stage of the pipelined RISC-V CPU.
- Owns the program counter and picks the next PC: sequential PC+4, or the branch/jump redirect target from EX.
- Drives a request/ready handshake to instruction memory and loads the IF/ID pipeline register that feeds decode.
- A one-entry skid buffer absorbs hazard-unit stalls; in-flight fetches are dropped on redirect.

Parameters:
XLEN, 32, width of PC and addresses
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0013, instruction driven on IF/ID for bubbles (addi x0,x0,0)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset, asynchronous, active-low
stall  input  1  hazard unit: hold IF/ID and PC
redirect_valid  input  1  EX resolved taken branch/jump this cycle
redirect_pc  input  XLEN  redirect target; bits[1:0] ignored (treated as 0)
imem_req  output  1  fetch request valid
imem_addr  output  XLEN  fetch address, word aligned
imem_ready  input  1  memory returns imem_rdata this cycle (completes the request)
imem_rdata  input  32  fetched instruction
if_id_valid  output  1  IF/ID holds a real instruction
if_id_pc  output  XLEN  PC of the IF/ID instruction
if_id_instr  output  32  IF/ID instruction

Behaviour:
- Reset (async on rst_n low):
  - state=BOOT, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC.
  - if_id_valid=0, if_id_pc=0, if_id_instr=NOP_INSTR, skid empty.
- FSM states: BOOT, FETCH, HOLD, DROP. All outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.
- BOOT: imem_req=0; next state FETCH unconditionally. The first request is issued the cycle after reset deasserts.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - Handshake: once asserted, imem_req and imem_addr hold stable until imem_ready=1. Exception: in the same cycle as ready.
  - ready & !stall & !redirect: IF/ID<={1,pc,imem_rdata}, pc<=pc+4, stay FETCH. Throughput is 1 instr/cycle with a zero-wait memory.
  - ready & stall & !redirect: rdata and pc go to skid, pc<=pc+4, IF/ID holds, go HOLD.
  - !ready & stall: IF/ID holds, request stays pending.
  - !ready & !stall: IF/ID<=bubble (valid=0, instr=NOP_INSTR, pc unchanged).
- HOLD:
  - imem_req=0.
  - While stall=1: hold everything.
  - stall=0: IF/ID<=skid contents, skid empty, go FETCH.
- DROP (wrong-path request in flight):
  - imem_req=1, imem_addr=old outstanding address, held stable.
  - imem_rdata is discarded on ready; IF/ID stays bubble.
  - On ready: pc<=pending_pc, go FETCH.
- Redirect priority: redirect_valid overrides stall in every state.
  - IF/ID<=bubble, skid cleared.
  - FETCH & !ready: pending_pc<=redirect_pc, go DROP.
  - FETCH & ready: rdata discarded, pc<=redirect_pc, stay FETCH.
  - HOLD or BOOT: pc<=redirect_pc, go FETCH.
  - DROP & !ready: pending_pc<=newest redirect_pc, stay DROP.
  - DROP & ready: pc<=redirect_pc, go FETCH.
- Arithmetic: pc+4 is modulo 2^XLEN. 32'hFFFF_FFFC wraps to 0 with no error flag.
- Bubble definition: if_id_valid=0 and if_id_instr=NOP_INSTR; if_id_pc is don't-care, but the model checks it unchanged.
- Mid-operation reset: everything returns to reset values immediately. Any pending memory response after reset is ignored because imem_req=0 in BOOT.

Test Plan:
- Reset release, imem_ready tied 1, rdata=addr-derived:
  - imem_req rises 1 cycle after rst_n high; addresses 0,4,8,12 on consecutive cycles.
  - if_id_pc follows 0,4,8 one cycle later with matching instr; if_id_valid=1 continuously.
- stall=1 for 3 cycles while ready=1 at pc=8:
  - state HOLD, imem_req=0, IF/ID frozen at pc=4.
  - After stall drops: IF/ID gets pc=8 then pc=12; no instruction lost or duplicated.
- Memory wait 2 cycles at addr 0x10 plus redirect_valid to 0x100 in the first wait cycle:
  - imem_addr stays 0x10 until ready, response discarded.
  - Next request is addr 0x100; IF/ID bubbles (instr=0x00000013) until the 0x100 instruction arrives.
- redirect_valid with stall=1 and ready=1, redirect_pc=0x203:
  - IF/ID bubble next cycle; next imem_addr=0x200 (low bits cleared).
- RESET_PC=32'hFFFF_FFF8, ready=1: addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
- rst_n pulled low during DROP with ready=0:
  - Outputs go to reset values asynchronously; stale rdata presented after release is never captured.
